// File: rtl/pipe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_pkg                                                              |
// | Shared skid-register state encoding and stage payload layouts.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   localparam logic [31:0] PC_INIT = 32'hBFC0_0000;

   // EX/MEM payload: {pc, memop, alu, wreg, wa}
   localparam int EXMEM_WA_LSB    = 0;
   localparam int EXMEM_WA_W      = 5;
   localparam int EXMEM_WREG_LSB  = 5;
   localparam int EXMEM_ALU_LSB   = 6;
   localparam int EXMEM_ALU_W     = 32;
   localparam int EXMEM_MEMOP_LSB = 38;
   localparam int EXMEM_MEMOP_W   = 4;
   localparam int EXMEM_PC_LSB    = 42;
   localparam int EXMEM_PC_W      = 32;
   localparam int EXMEM_W         = 74;

   // MEM/WB payload: {pc, wdata, wreg, wa}
   localparam int MEMWB_WA_LSB    = 0;
   localparam int MEMWB_WA_W      = 5;
   localparam int MEMWB_WREG_LSB  = 5;
   localparam int MEMWB_WDATA_LSB = 6;
   localparam int MEMWB_WDATA_W   = 32;
   localparam int MEMWB_PC_LSB    = 38;
   localparam int MEMWB_PC_W      = 32;
   localparam int MEMWB_W         = 70;

   // PC sits in the top field, so bubbles carry PC_INIT with write-enables low
   localparam logic [EXMEM_W-1:0] EXMEM_RST_VALUE = {PC_INIT, {EXMEM_PC_LSB{1'b0}}};
   localparam logic [MEMWB_W-1:0] MEMWB_RST_VALUE = {PC_INIT, {MEMWB_PC_LSB{1'b0}}};

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sat_counter                                                           |
// | Saturating up-counter with synchronous clear; clear beats increment.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != c_max)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_stage_skid_reg                                                   |
// | Inter-stage register with 2-entry skid buffer and registered ready.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W       = 64,
   parameter logic [DATA_W-1:0] RST_VALUE    = {DATA_W{1'b0}},
   parameter bit                GATE_INVALID = 1'b1,
   parameter int                CNT_W        = 16
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic [DATA_W-1:0] w_main_nxt;
   logic [DATA_W-1:0] w_skid_nxt;
   logic              r_in_ready;
   logic              w_accept;
   logic              w_emit;

   assign out_valid = (r_state != ST_EMPTY);
   assign in_ready  = r_in_ready;
   assign occupancy = r_state;
   assign w_accept  = in_valid & r_in_ready;
   assign w_emit    = out_valid & out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_ONE;
               w_main_nxt  = in_data;
            end
         end
         ST_ONE: begin
            if (w_accept && w_emit) begin
               w_main_nxt  = in_data;
            end else if (w_accept) begin
               w_state_nxt = ST_TWO;
               w_skid_nxt  = in_data;
            end else if (w_emit) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_emit) begin
               w_state_nxt = ST_ONE;
               w_main_nxt  = r_skid;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Ready is computed from the next state so it never depends on out_ready combinationally
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst || flush) begin
         r_state    <= ST_EMPTY;
         r_main     <= RST_VALUE;
         r_skid     <= RST_VALUE;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_main     <= w_main_nxt;
         r_skid     <= w_skid_nxt;
         r_in_ready <= (w_state_nxt != ST_TWO);
      end
   end

   generate
      if (GATE_INVALID) begin : g_gate_invalid
         assign out_data = out_valid ? r_main : RST_VALUE;
      end else begin : g_hold_data
         assign out_data = r_main;
      end
   endgenerate

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (cpu_clk_50M),
      .rst   (cpu_rst),
      .i_inc (out_valid & ~out_ready),
      .i_clr (stall_clr),
      .o_cnt (stall_cnt)
   );

endmodule : pipe_stage_skid_reg
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pipe_stage_skid_reg                                                |
// | Directed table, corner sequences and random run against a queue model.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_pipe_stage_skid_reg;

   localparam int            DW   = 16;
   localparam int            CW   = 4;
   localparam logic [DW-1:0] RV   = 16'h5A3C;
   localparam int            CMAX = 15;
   localparam bit            N    = 1'b0;
   localparam bit            Y    = 1'b1;

   logic          clk = 1'b0;
   logic          rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, stall_clr = 1'b0;
   logic [DW-1:0] in_data = '0;

   logic          in_ready, out_valid, in_ready_h, out_valid_h;
   logic [DW-1:0] out_data, out_data_h;
   logic [1:0]    occupancy, occupancy_h;
   logic [CW-1:0] stall_cnt, stall_cnt_h;

   always #5 clk = ~clk;

   pipe_stage_skid_reg #(.DATA_W(DW), .RST_VALUE(RV), .GATE_INVALID(1'b1), .CNT_W(CW)) dut (
      .cpu_clk_50M(clk), .cpu_rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr));

   pipe_stage_skid_reg #(.DATA_W(DW), .RST_VALUE(RV), .GATE_INVALID(1'b0), .CNT_W(CW)) dut_h (
      .cpu_clk_50M(clk), .cpu_rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
      .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h),
      .occupancy(occupancy_h), .stall_cnt(stall_cnt_h), .stall_clr(stall_clr));

   // Reference model: the held payloads as a FIFO queue plus a plain integer counter
   logic [DW-1:0] mq[$];
   int            m_cnt  = 0;
   logic [DW-1:0] m_hold = RV;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      bit acc, emi, stl;
      acc = in_valid && (mq.size() < 2);
      emi = out_ready && (mq.size() > 0);
      stl = !out_ready && (mq.size() > 0);
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_cnt  = 0;
         m_hold = RV;
      end else begin
         if (stall_clr) m_cnt = 0;
         else if (stl && m_cnt < CMAX) m_cnt++;
         if (flush) begin
            mq.delete();
            m_hold = RV;
         end else begin
            if (emi) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
            if (mq.size() > 0) m_hold = mq[0];
         end
      end
      #1;
   endtask

   task automatic chk_model();
      logic [DW-1:0] head;
      head = (mq.size() > 0) ? mq[0] : RV;
      chk("rnd.out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("rnd.out_data",  32'(out_data),  32'(head));
      chk("rnd.in_ready",  32'(in_ready),  32'(mq.size() < 2));
      chk("rnd.occupancy", 32'(occupancy), 32'(mq.size()));
      chk("rnd.stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("rnd.h.out_valid", 32'(out_valid_h), 32'(mq.size() > 0));
      chk("rnd.h.out_data",  32'(out_data_h),  32'(m_hold));
      chk("rnd.h.in_ready",  32'(in_ready_h),  32'(mq.size() < 2));
      chk("rnd.h.occupancy", 32'(occupancy_h), 32'(mq.size()));
      chk("rnd.h.stall_cnt", 32'(stall_cnt_h), 32'(m_cnt));
   endtask

   typedef struct {
      logic          rst, flush, iv;
      logic [DW-1:0] d;
      logic          ordy, clr;
      logic          ev;
      logic [DW-1:0] ed;
      logic          erdy;
      logic [1:0]    eocc;
      int            ecnt;
   } vec_t;

   vec_t tbl[24];

   function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [DW-1:0] d,
                               input logic o, input logic c, input logic ev, input logic [DW-1:0] ed,
                               input logic er, input logic [1:0] eo, input int ec);
      vec_t t;
      t.rst = r; t.flush = f; t.iv = v; t.d = d; t.ordy = o; t.clr = c;
      t.ev = ev; t.ed = ed; t.erdy = er; t.eocc = eo; t.ecnt = ec;
      return t;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bias;
      //               rst flush iv  data      ordy clr | ev  data      rdy  occ  cnt
      tbl[0]  = mk(Y,  N,  N,  16'h0000, N,   N,    N,  RV,       Y,   2'd0, 0);
      tbl[1]  = mk(Y,  N,  N,  16'h0000, N,   N,    N,  RV,       Y,   2'd0, 0);
      for (int k = 1; k <= 8; k++)
         tbl[1+k] = mk(N, N, Y, DW'(k), Y, N, Y, DW'(k), Y, 2'd1, 0);
      tbl[10] = mk(N,  N,  N,  16'h0000, Y,   N,    N,  RV,       Y,   2'd0, 0);
      tbl[11] = mk(N,  N,  Y,  16'h000A, N,   N,    Y,  16'h000A, Y,   2'd1, 0);
      tbl[12] = mk(N,  N,  Y,  16'h000B, N,   N,    Y,  16'h000A, N,   2'd2, 1);
      tbl[13] = mk(N,  N,  Y,  16'h000C, N,   N,    Y,  16'h000A, N,   2'd2, 2);
      tbl[14] = mk(N,  N,  N,  16'h0000, Y,   N,    Y,  16'h000B, Y,   2'd1, 2);
      tbl[15] = mk(N,  N,  Y,  16'h000C, Y,   N,    Y,  16'h000C, Y,   2'd1, 2);
      tbl[16] = mk(N,  N,  N,  16'h0000, Y,   N,    N,  RV,       Y,   2'd0, 2);
      tbl[17] = mk(N,  N,  Y,  16'h0011, N,   N,    Y,  16'h0011, Y,   2'd1, 2);
      tbl[18] = mk(N,  N,  Y,  16'h0022, N,   N,    Y,  16'h0011, N,   2'd2, 3);
      tbl[19] = mk(N,  Y,  Y,  16'h0033, N,   N,    N,  RV,       Y,   2'd0, 4);
      tbl[20] = mk(N,  N,  N,  16'h0000, Y,   N,    N,  RV,       Y,   2'd0, 4);
      tbl[21] = mk(N,  N,  Y,  16'hFFFF, Y,   N,    Y,  16'hFFFF, Y,   2'd1, 4);
      tbl[22] = mk(N,  N,  N,  16'h0000, Y,   N,    N,  RV,       Y,   2'd0, 4);
      tbl[23] = mk(N,  N,  N,  16'h0000, Y,   Y,    N,  RV,       Y,   2'd0, 0);

      for (int i = 0; i < 24; i++) begin
         rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv; in_data = tbl[i].d;
         out_ready = tbl[i].ordy; stall_clr = tbl[i].clr;
         step();
         chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d.out_data", i),  32'(out_data),  32'(tbl[i].ed));
         chk($sformatf("tbl%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].erdy));
         chk($sformatf("tbl%0d.occupancy", i), 32'(occupancy), 32'(tbl[i].eocc));
         chk($sformatf("tbl%0d.stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].ecnt));
      end
      chk("nogate.hold_ffff", 32'(out_data_h), 32'h0000FFFF);
      chk("nogate.valid_low", 32'(out_valid_h), 32'd0);

      // Saturation: one entry held with downstream stalled
      stall_clr = 1'b0; in_valid = 1'b1; in_data = 16'h0077; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      chk("sat.cnt10", 32'(stall_cnt), 32'd10);
      repeat (10) step();
      chk("sat.cnt15", 32'(stall_cnt), 32'd15);
      chk("sat.data", 32'(out_data), 32'h0077);
      stall_clr = 1'b1;
      step();
      chk("sat.clr_wins", 32'(stall_cnt), 32'd0);
      stall_clr = 1'b0;
      step();
      chk("sat.recount", 32'(stall_cnt), 32'd1);

      // Reset with two entries held; flush and clear asserted too
      in_valid = 1'b1; in_data = 16'h0088;
      step();
      chk("rstmid.occ2", 32'(occupancy), 32'd2);
      rst = 1'b1; flush = 1'b1; stall_clr = 1'b1; in_data = 16'h0099;
      step();
      chk("rstmid.occ", 32'(occupancy), 32'd0);
      chk("rstmid.valid", 32'(out_valid), 32'd0);
      chk("rstmid.cnt", 32'(stall_cnt), 32'd0);
      chk("rstmid.ready", 32'(in_ready), 32'd1);
      chk("rstmid.data", 32'(out_data), 32'(RV));
      rst = 1'b0; flush = 1'b0; stall_clr = 1'b0; in_data = 16'h0044; out_ready = 1'b1;
      step();
      chk("resume.d44", 32'(out_data), 32'h0044);
      in_data = 16'h0045;
      step();
      chk("resume.d45", 32'(out_data), 32'h0045);
      in_valid = 1'b0;
      step();
      chk("resume.idle", 32'(out_valid), 32'd0);

      // Random traffic with drifting backpressure
      bias = 70;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) bias = int'($urandom_range(5, 100));
         rst       = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 59) == 0);
         stall_clr = ($urandom_range(0, 79) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = DW'($urandom);
         out_ready = (int'($urandom_range(0, 99)) < bias);
         step();
         chk_model();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pipe_stage_skid_reg
`default_nettype wire
